// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_state_t  : bus-transaction state machine encoding
//   FMT_*        : RISC-V funct3 load/store size encodings
//   access_legal : legality of a single-enable request (format, alignment, direction)
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    // Unsigned formats only exist for loads; halfwords need even addresses,
    // words need 4-byte alignment. Unknown encodings are always illegal.
    function automatic logic access_legal(input logic [2:0] format,
                                          input logic [1:0] addr_low,
                                          input logic       is_store);
        logic legal;
        case (format)
            FMT_B:   legal = 1'b1;
            FMT_H:   legal = ~addr_low[0];
            FMT_W:   legal = (addr_low == 2'b00);
            FMT_BU:  legal = ~is_store;
            FMT_HU:  legal = ~is_store & ~addr_low[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_data_aligner.sv
// load_data_aligner: combinational lane logic shared by both directions.
//   bus_data     in  BUS_WIDTH  raw read data from the bus
//   offset       in  OFFSET_W   byte offset of the access inside the bus word
//   format       in  3          funct3 size/sign encoding
//   store_data   in  32         right-aligned store data
//   load_result  out 32         shifted and sign/zero-extended load value
//   store_wdata  out BUS_WIDTH  store data replicated across every lane
//   store_strobe out BUS_BYTES  byte enables for the addressed lanes
module load_data_aligner
    import lsu_pkg::*;
#(
    parameter  int BUS_WIDTH = 32,
    localparam int BUS_BYTES = BUS_WIDTH / 8,
    localparam int OFFSET_W  = $clog2(BUS_BYTES)
) (
    input  logic [BUS_WIDTH-1:0] bus_data,
    input  logic [OFFSET_W-1:0]  offset,
    input  logic [2:0]           format,
    input  logic [31:0]          store_data,
    output logic [31:0]          load_result,
    output logic [BUS_WIDTH-1:0] store_wdata,
    output logic [BUS_BYTES-1:0] store_strobe
);

    logic [31:0]          shifted;
    logic [BUS_BYTES-1:0] lane_mask;

    // NOTE: every signal written here gets a default first, so formats not
    // listed in the case fall through to a value instead of inferring a latch.
    always_comb begin
        shifted     = 32'(bus_data >> {offset, 3'b000});
        load_result = 32'h0;
        case (format)
            FMT_B:   load_result = {{24{shifted[7]}}, shifted[7:0]};
            FMT_BU:  load_result = {24'h0, shifted[7:0]};
            FMT_H:   load_result = {{16{shifted[15]}}, shifted[15:0]};
            FMT_HU:  load_result = {16'h0, shifted[15:0]};
            FMT_W:   load_result = shifted;
            default: ;
        endcase
    end

    // Replicating the data means the slave only needs the strobes to pick
    // the right lane; no per-offset data shifter is required.
    always_comb begin
        store_wdata = '0;
        lane_mask   = '0;
        case (format)
            FMT_B: begin
                store_wdata = {BUS_BYTES{store_data[7:0]}};
                lane_mask   = BUS_BYTES'(4'h1);
            end
            FMT_H: begin
                store_wdata = {(BUS_BYTES / 2){store_data[15:0]}};
                lane_mask   = BUS_BYTES'(4'h3);
            end
            FMT_W: begin
                store_wdata = {(BUS_BYTES / 4){store_data}};
                lane_mask   = BUS_BYTES'(4'hF);
            end
            default: ;
        endcase
        store_strobe = lane_mask << offset;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: adapts the core's single-cycle load/store port to a
// valid/ready memory bus with unbounded latency, stalling the core meanwhile.
//   clock, reset (async, active-low)
//   core_*  : request from the core datapath; stall, fault and load data back
//   mem_req_*  : one registered bus request per access (valid/ready handshake)
//   mem_resp_* : read data or write acknowledge, accepted only in RESP
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int BUS_WIDTH = 32,
    localparam int BUS_BYTES = BUS_WIDTH / 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 core_read_enable,
    input  logic                 core_write_enable,
    input  logic [2:0]           core_format,
    input  logic [31:0]          core_address,
    input  logic [31:0]          core_write_data,
    output logic [31:0]          core_read_data,
    output logic                 core_stall,
    output logic                 core_access_fault,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_write,
    output logic [31:0]          mem_req_address,
    output logic [BUS_WIDTH-1:0] mem_req_wdata,
    output logic [BUS_BYTES-1:0] mem_req_strobe,
    input  logic                 mem_resp_valid,
    input  logic [BUS_WIDTH-1:0] mem_resp_data
);

    localparam int          OFFSET_W  = $clog2(BUS_BYTES);
    localparam logic [31:0] ADDR_MASK = ~32'(BUS_BYTES - 1);

    lsu_state_t           state, next_state;
    logic [2:0]           req_format;
    logic [OFFSET_W-1:0]  req_offset;
    logic [31:0]          read_data_q;
    logic                 any_request, legal_request;
    logic [OFFSET_W-1:0]  align_offset;
    logic [2:0]           align_format;
    logic [31:0]          load_result;
    logic [BUS_WIDTH-1:0] store_wdata;
    logic [BUS_BYTES-1:0] store_strobe;

    assign any_request   = core_read_enable | core_write_enable;
    assign legal_request = (core_read_enable ^ core_write_enable)
                         && access_legal(core_format, core_address[1:0], core_write_enable);

    // One aligner serves both directions: in IDLE it places store data from
    // the live core inputs; afterwards it extracts load data using the
    // captured offset and format.
    always_comb begin
        align_offset = req_offset;
        align_format = req_format;
        if (state == ST_IDLE) begin
            align_offset = core_address[OFFSET_W-1:0];
            align_format = core_format;
        end
    end

    load_data_aligner #(.BUS_WIDTH(BUS_WIDTH)) u_aligner (
        .bus_data     (mem_resp_data),
        .offset       (align_offset),
        .format       (align_format),
        .store_data   (core_write_data),
        .load_result  (load_result),
        .store_wdata  (store_wdata),
        .store_strobe (store_strobe)
    );

    always_comb begin
        next_state        = state;
        mem_req_valid     = 1'b0;
        core_stall        = 1'b0;
        core_access_fault = 1'b0;
        core_read_data    = 32'h0;
        case (state)
            ST_IDLE: begin
                if (legal_request) begin
                    next_state = ST_REQ;
                    core_stall = 1'b1;
                end else if (any_request) begin
                    core_access_fault = 1'b1;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                core_stall    = 1'b1;
                if (mem_req_ready) next_state = ST_RESP;
            end
            ST_RESP: begin
                core_stall = 1'b1;
                if (mem_resp_valid) next_state = ST_DONE;
            end
            ST_DONE: begin
                core_read_data = read_data_q;
                next_state     = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            mem_req_write   <= 1'b0;
            mem_req_address <= 32'h0;
            mem_req_wdata   <= '0;
            mem_req_strobe  <= '0;
            req_format      <= FMT_B;
            req_offset      <= '0;
            read_data_q     <= 32'h0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && legal_request) begin
                mem_req_write   <= core_write_enable;
                mem_req_address <= core_address & ADDR_MASK;
                mem_req_wdata   <= core_write_enable ? store_wdata  : '0;
                mem_req_strobe  <= core_write_enable ? store_strobe : '0;
                req_format      <= core_format;
                req_offset      <= core_address[OFFSET_W-1:0];
            end
            if (state == ST_RESP && mem_resp_valid) begin
                read_data_q <= mem_req_write ? 32'h0 : load_result;
            end
        end
    end

endmodule
